// File: rtl/regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile : integer register file with two combinational read ports, one
//           writeback port and a per-register pending-write scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     reg_write_i,
  input  logic [$clog2(NREGS)-1:0] reg_waddr_i,
  input  logic [XLEN-1:0]          reg_wdata_i,
  input  logic [$clog2(NREGS)-1:0] rs1_addr_i,
  input  logic [$clog2(NREGS)-1:0] rs2_addr_i,
  output logic [XLEN-1:0]          rs1_data_o,
  output logic [XLEN-1:0]          rs2_data_o,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  input  logic                     issue_valid_i,
  input  logic [$clog2(NREGS)-1:0] issue_rd_i,
  output logic                     issue_ready_o,
  output logic                     wb_err_o
);

  localparam int              AW        = $clog2(NREGS);
  localparam logic [PEND_W-1:0] C_CNT_MAX = '1;

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [PEND_W-1:0] cnt_q  [NREGS];
  logic [PEND_W-1:0] cnt_d  [NREGS];
  logic              err_q, err_d;

  logic [NREGS-1:0]  we_w;
  logic [NREGS-1:0]  inc_w;
  logic [NREGS-1:0]  dec_w;
  logic              rs1_byp_w, rs2_byp_w;

  // Ready depends only on registered counts, so a same-cycle writeback
  // cannot free a saturated slot combinationally.
  assign issue_ready_o = (issue_rd_i == '0) | (cnt_q[issue_rd_i] != C_CNT_MAX);

  generate
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
        assign we_w[r]  = 1'b0;
        assign inc_w[r] = 1'b0;
        assign dec_w[r] = 1'b0;
      end else begin : g_xn
        assign we_w[r]  = reg_write_i & (reg_waddr_i == AW'(r));
        assign inc_w[r] = issue_valid_i & issue_ready_o & (issue_rd_i == AW'(r));
        assign dec_w[r] = we_w[r] & (cnt_q[r] != '0);
      end
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_w[r] && !dec_w[r]) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (dec_w[r] && !inc_w[r]) begin
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  assign err_d = err_q | (reg_write_i & (reg_waddr_i != '0) & (cnt_q[reg_waddr_i] == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (we_w[r]) begin
          regs_q[r] <= reg_wdata_i;
        end
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign rs1_byp_w = (BYPASS != 0) & reg_write_i & (reg_waddr_i == rs1_addr_i);
  assign rs2_byp_w = (BYPASS != 0) & reg_write_i & (reg_waddr_i == rs2_addr_i);

  assign rs1_data_o = (rs1_addr_i == '0) ? '0 : (rs1_byp_w ? reg_wdata_i : regs_q[rs1_addr_i]);
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 : (rs2_byp_w ? reg_wdata_i : regs_q[rs2_addr_i]);

  assign rs1_busy_o = (cnt_q[rs1_addr_i] != '0);
  assign rs2_busy_o = (cnt_q[rs2_addr_i] != '0);
  assign wb_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile : directed vector table, async-reset sequence and randomized
//              traffic checked against an array-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile;

  localparam int CMAX = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_write_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        wb_err_o;

  regfile #(.XLEN(32), .NREGS(32), .PEND_W(2), .BYPASS(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_write_i(reg_write_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_ready_o(issue_ready_o), .wb_err_o(wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic        iv;
    logic [4:0]  rd;
    logic [31:0] e1, e2;
    logic        b1, b2, rdy, err;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model: architectural contents, pending counts, sticky error.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  logic        m_err;

  function automatic vec_t mk(logic wr, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] a1, logic [4:0] a2, logic iv, logic [4:0] rd,
                              logic [31:0] e1, logic [31:0] e2,
                              logic b1, logic b2, logic rdy, logic err);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.a1 = a1; v.a2 = a2; v.iv = iv; v.rd = rd;
    v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2; v.rdy = rdy; v.err = err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  task automatic drive(input logic wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] rd);
    reg_write_i = wr; reg_waddr_i = wa; reg_wdata_i = wd;
    rs1_addr_i = a1; rs2_addr_i = a2; issue_valid_i = iv; issue_rd_i = rd;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (reg_write_i && reg_waddr_i == a) return reg_wdata_i;
    return m_regs[a];
  endfunction

  function automatic logic m_ready();
    return (issue_rd_i == 0) || (m_cnt[issue_rd_i] != CMAX);
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".rs1"}, rs1_data_o, m_read(rs1_addr_i));
    check({tag, ".rs2"}, rs2_data_o, m_read(rs2_addr_i));
    check({tag, ".b1"}, {31'b0, rs1_busy_o}, {31'b0, m_cnt[rs1_addr_i] != 0});
    check({tag, ".b2"}, {31'b0, rs2_busy_o}, {31'b0, m_cnt[rs2_addr_i] != 0});
    check({tag, ".rdy"}, {31'b0, issue_ready_o}, {31'b0, m_ready()});
    check({tag, ".err"}, {31'b0, wb_err_o}, {31'b0, m_err});
  endtask

  // Apply the current inputs to the model across one rising edge, then
  // return at the following falling edge.
  task automatic advance();
    logic       inc, dec, wr_nz;
    logic [4:0] wa, rd;
    logic [31:0] wd;
    wa    = reg_waddr_i; rd = issue_rd_i; wd = reg_wdata_i;
    wr_nz = reg_write_i && wa != 0;
    inc   = issue_valid_i && m_ready() && rd != 0;
    dec   = wr_nz && m_cnt[wa] != 0;
    @(posedge clk_i);
    if (wr_nz) begin
      if (m_cnt[wa] == 0) m_err = 1'b1;
      m_regs[wa] = wd;
    end
    if (dec) m_cnt[wa] = m_cnt[wa] - 1;
    if (inc) m_cnt[rd] = m_cnt[rd] + 1;
    @(negedge clk_i);
  endtask

  task automatic step(input string tag, input logic wr, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic iv, input logic [4:0] rd);
    drive(wr, wa, wd, a1, a2, iv, rd);
    #1;
    check_model(tag);
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt [20];
    vt[0]  = mk(0, 0, 32'h0,        0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[1]  = mk(0, 0, 32'h0,        0,  0, 1, 0, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[2]  = mk(1, 0, 32'hDEADBEEF, 0,  0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[3]  = mk(0, 0, 32'h0,        5,  0, 1, 5, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[4]  = mk(1, 5, 32'h12345678, 5,  5, 0, 5, 32'h12345678, 32'h12345678, 1, 1, 1, 0);
    vt[5]  = mk(0, 0, 32'h0,        5,  0, 0, 5, 32'h12345678, 32'h0,        0, 0, 1, 0);
    vt[6]  = mk(0, 0, 32'h0,        7,  0, 1, 7, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[7]  = mk(0, 0, 32'h0,        7,  0, 1, 7, 32'h0,        32'h0,        1, 0, 1, 0);
    vt[8]  = mk(0, 0, 32'h0,        7,  0, 1, 7, 32'h0,        32'h0,        1, 0, 1, 0);
    vt[9]  = mk(0, 0, 32'h0,        7,  0, 1, 7, 32'h0,        32'h0,        1, 0, 0, 0);
    vt[10] = mk(1, 7, 32'hA1,       7,  0, 1, 7, 32'hA1,       32'h0,        1, 0, 0, 0);
    vt[11] = mk(1, 7, 32'hA2,       7,  0, 0, 7, 32'hA2,       32'h0,        1, 0, 1, 0);
    vt[12] = mk(1, 7, 32'hA3,       7,  0, 0, 7, 32'hA3,       32'h0,        1, 0, 1, 0);
    vt[13] = mk(0, 0, 32'h0,        7,  0, 0, 7, 32'hA3,       32'h0,        0, 0, 1, 0);
    vt[14] = mk(0, 0, 32'h0,        9,  0, 1, 9, 32'h0,        32'h0,        0, 0, 1, 0);
    vt[15] = mk(1, 9, 32'h99,       9,  0, 1, 9, 32'h99,       32'h0,        1, 0, 1, 0);
    vt[16] = mk(0, 0, 32'h0,        9,  0, 0, 9, 32'h99,       32'h0,        1, 0, 1, 0);
    vt[17] = mk(1, 12, 32'hCAFE,    12, 9, 0, 0, 32'hCAFE,     32'h99,       0, 1, 1, 0);
    vt[18] = mk(0, 0, 32'h0,        12, 9, 0, 0, 32'hCAFE,     32'h99,       0, 1, 1, 1);
    vt[19] = mk(0, 0, 32'h0,        0,  9, 0, 0, 32'h0,        32'h99,       0, 1, 1, 1);

    rst_ni = 1'b0;
    drive(0, 0, 0, 3, 4, 0, 3);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_model("reset");
    rst_ni = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].a1, vt[i].a2, vt[i].iv, vt[i].rd);
      #1;
      check($sformatf("v%0d.rs1", i), rs1_data_o, vt[i].e1);
      check($sformatf("v%0d.rs2", i), rs2_data_o, vt[i].e2);
      check($sformatf("v%0d.b1", i), {31'b0, rs1_busy_o}, {31'b0, vt[i].b1});
      check($sformatf("v%0d.b2", i), {31'b0, rs2_busy_o}, {31'b0, vt[i].b2});
      check($sformatf("v%0d.rdy", i), {31'b0, issue_ready_o}, {31'b0, vt[i].rdy});
      check($sformatf("v%0d.err", i), {31'b0, wb_err_o}, {31'b0, vt[i].err});
      advance();
    end

    // Saturate x3, then hit reset between edges with state everywhere.
    step("sat0", 0, 0, 0, 3, 0, 1, 3);
    step("sat1", 0, 0, 0, 3, 0, 1, 3);
    step("sat2", 0, 0, 0, 3, 0, 1, 3);
    drive(0, 0, 0, 12, 9, 0, 3);
    #1;
    check("pre_rst.rdy", {31'b0, issue_ready_o}, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst.rs1", rs1_data_o, 32'h0);
    check("async_rst.rs2", rs2_data_o, 32'h0);
    check("async_rst.b2", {31'b0, rs2_busy_o}, 32'h0);
    check("async_rst.rdy", {31'b0, issue_ready_o}, 32'h1);
    check("async_rst.err", {31'b0, wb_err_o}, 32'h0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_rst", 0, 0, 0, 12, 3, 0, 3);

    for (int i = 0; i < 600; i++) begin
      logic        wr, iv;
      logic [4:0]  wa, a1, a2, rd;
      int          off;
      wr = ($urandom_range(0, 1) == 1);
      wa = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        off = $urandom_range(1, 7);
        for (int k = 0; k < 7; k++) begin
          if (m_cnt[((off + k) % 7) + 1] != 0) begin
            wa = 5'(((off + k) % 7) + 1);
            break;
          end
        end
      end
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      iv = ($urandom_range(0, 2) != 0);
      rd = 5'($urandom_range(0, 7));
      step($sformatf("rnd%0d", i), wr, wa, $urandom, a1, a2, iv, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
